// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer.
// Phase table, state encoding and index step sizes.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] PHASE_TAB [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  localparam logic [2:0] STEP_HALF = 3'd1;
  localparam logic [2:0] STEP_FULL = 3'd2;

  function automatic logic [3:0] phase(
    input logic [2:0] i
  );
    return PHASE_TAB[i];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer plus registered rising-edge detector
// for slow asynchronous inputs sampled as data.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic d_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], d_in};
      hist_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/stepper_seq.sv
// 4-phase unipolar stepper sequencer driven by clk_div ticks.
// Runs nsteps moves, tracks position, reports busy/done.
module stepper_seq
  import stepper_pkg::*;
#(
  parameter int STEPS_W     = 16,
  parameter int POS_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic                    clk_div,
  input  logic                    start,
  input  logic                    dir,
  input  logic                    half_step,
  input  logic [STEPS_W-1:0]      nsteps,
  input  logic                    abort,
  input  logic                    hold,
  output logic [3:0]              coil,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] pos
);

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [STEPS_W-1:0]        rem_q, rem_d;
  logic                      dir_q, dir_d;
  logic                      half_q, half_d;
  logic signed [POS_W-1:0]   pos_d;
  logic [3:0]                coil_d;
  logic [2:0]                stp;
  logic                      tick;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .d_in      (clk_div),
    .rise_pulse(tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    half_d  = half_q;
    pos_d   = pos;
    stp     = half_q ? STEP_HALF : STEP_FULL;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nsteps != '0) begin
            dir_d   = dir;
            half_d  = half_step;
            rem_d   = nsteps;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // abort wins over a coincident tick
        if (abort) begin
          state_d = DONE;
        end else if (tick) begin
          idx_d = dir_q ? idx_q + stp : idx_q - stp;
          pos_d = dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
          rem_d = rem_q - STEPS_W'(1);
          if (rem_q == STEPS_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (1'b1)
      (state_d == IDLE) && !hold: coil_d = 4'b0000;
      default:                    coil_d = phase(idx_d);
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      pos     <= '0;
      coil    <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      pos     <= pos_d;
      coil    <= coil_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_stepper_seq.sv
// Scoreboard bench for stepper_seq: stimulus pushes expected
// step/done events, a negedge monitor pops and compares them.
module tb_stepper_seq;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_div = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        half_step = 1'b0;
  logic [15:0] nsteps = '0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic signed [15:0] pos;

  stepper_seq #(
    .STEPS_W(16),
    .POS_W(16),
    .SYNC_STAGES(SYNC)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .clk_div  (clk_div),
    .start    (start),
    .dir      (dir),
    .half_step(half_step),
    .nsteps   (nsteps),
    .abort    (abort),
    .hold     (hold),
    .coil     (coil),
    .busy     (busy),
    .done     (done),
    .pos      (pos)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit          is_done;
    int          at;
    logic [3:0]  coil;
    logic [15:0] pos;
  } ev_t;

  ev_t q[$];

  logic [3:0] tab [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  int m_idx = 0;
  int m_pos = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit d);
    ev_t e;
    if (q.size() == 0) begin
      nchk++;
      nerr++;
      $display("FAIL spurious %s: coil %b pos %0d, none expected",
               d ? "done" : "step", coil, pos);
    end else begin
      e = q.pop_front();
      chk("event kind", 32'(d), 32'(e.is_done));
      chk("event cycle", cyc, e.at);
      chk("event coil", 32'(coil), 32'(e.coil));
      chk("event pos", 32'($unsigned(pos)), 32'(e.pos));
      if (d) chk("busy at done", 32'(busy), 0);
    end
  endtask

  logic [15:0] prev_pos = '0;
  always @(negedge sysclk) begin
    if (!reset) begin
      prev_pos = pos;
    end else begin
      if (pos !== prev_pos) expect_ev(1'b0);
      if (done === 1'b1) expect_ev(1'b1);
      prev_pos = pos;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push(input bit d, input int at);
    ev_t e;
    e.is_done = d;
    e.at      = at;
    e.coil    = tab[m_idx];
    e.pos     = 16'(m_pos);
    q.push_back(e);
  endtask

  task automatic do_move(input bit d, input bit h, input int n,
                         input bit hd, input int abort_at,
                         input int rst_after);
    int c;
    int s;
    hold = hd;
    cyc_wait(3);
    chk("idle coil", 32'(coil), 32'(hd ? tab[m_idx] : 4'b0000));
    chk("idle busy", 32'(busy), 0);
    dir       = d;
    half_step = h;
    nsteps    = 16'(n);
    start     = 1'b1;
    c         = cyc;
    if (n == 0) push(1'b1, c + 1);
    cyc_wait(1);
    start     = 1'b0;
    dir       = 1'($urandom);
    half_step = 1'($urandom);
    nsteps    = 16'($urandom);
    if (n == 0) begin
      cyc_wait(3);
      return;
    end
    s = (h ? 1 : 2) * (d ? 1 : -1);
    for (int k = 1; k <= n; k++) begin
      cyc_wait(2);
      c = cyc;
      clk_div = 1'b1;
      if (k == abort_at) begin
        push(1'b1, c + LAT);
      end else begin
        m_idx = (m_idx + s + 8) % 8;
        m_pos = m_pos + (d ? 1 : -1);
        push(1'b0, c + LAT);
        if (k == n) push(1'b1, c + LAT);
      end
      for (int i = 1; i <= 8; i++) begin
        cyc_wait(1);
        if (k == 2 && i == 1) begin
          start  = 1'b1;
          nsteps = 16'($urandom_range(1, 9));
        end
        if (k == 2 && i == 2) start = 1'b0;
        if (i == LAT - 1) abort = (k == abort_at);
        if (i == LAT) begin
          abort   = 1'b0;
          clk_div = 1'b0;
        end
      end
      if (k == abort_at) break;
      if (k == rst_after) begin
        reset = 1'b0;
        cyc_wait(2);
        chk("rst coil", 32'(coil), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pos", 32'($unsigned(pos)), 0);
        m_idx = 0;
        m_pos = 0;
        reset = 1'b1;
        return;
      end
    end
    cyc_wait(3);
  endtask

  initial begin
    int d, h, n, hd, ab;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_div = ~clk_div;
      cyc_wait(1);
    end
    chk("reset coil", 32'(coil), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset pos", 32'($unsigned(pos)), 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clk_div = ~clk_div;
      cyc_wait(4);
    end
    clk_div = 1'b0;
    cyc_wait(6);
    chk("post-reset coil", 32'(coil), 0);
    chk("post-reset pos", 32'($unsigned(pos)), 0);

    do_move(1, 1, 3, 0, 0, 0);
    do_move(0, 0, 2, 1, 0, 0);
    do_move(1, 1, 5, 1, 2, 0);
    do_move(0, 1, 0, 0, 0, 0);
    do_move(1, 0, 5, 0, 0, 2);

    for (int i = 0; i < 3; i++) begin
      clk_div = 1'b1;
      cyc_wait(5);
      clk_div = 1'b0;
      cyc_wait(5);
    end
    chk("after mid-reset coil", 32'(coil), 0);
    chk("after mid-reset pos", 32'($unsigned(pos)), 0);
    do_move(1, 1, 1, 0, 0, 0);

    for (int r = 0; r < 24; r++) begin
      d  = int'($urandom_range(0, 1));
      h  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 6));
      hd = int'($urandom_range(0, 1));
      ab = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, n));
      do_move(1'(d), 1'(h), n, 1'(hd), ab, 0);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) cyc_wait(1);
    chk("queue drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
